hazard_sequencer: RTL
=====================

# hazard_sequencer

Stall/flush controller for the 5-stage pipeline with branch resolution in ID. Each cycle it inspects the instruction in IF/ID against producers in ID/EX and EX/MEM. It then drives the PC write enable, IF/ID write enable, IF/ID flush and ID/EX bubble insertion. A small FSM holds the second stall cycle of a load-then-branch dependency, and saturating counters record stall and flush cycles for performance checks. It sits beside the forwarding unit: forwarding covers every dependency it can, and this block stalls on the rest.

## Interface
- CNT_W, 16, width of each performance counter
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- IDEXMemRead  in  1  instruction in EX is a load
- IDEXRegWrite  in  1  instruction in EX writes a register
- IDEXDst  in  5  destination register of instruction in EX
- EXMEMMemRead  in  1  instruction in MEM is a load
- EXMEMDst  in  5  destination register of instruction in MEM
- IFIDRs  in  5  source register rs of instruction in ID
- IFIDRt  in  5  source register rt of instruction in ID
- IFIDUsesRt  in  1  instruction in ID reads rt (R-type, sw, beq)
- IFIDBeq  in  1  instruction in ID is a branch
- BranchTaken  in  1  ID-stage comparator says branch taken (valid only when no stall)
- CntClr  in  1  synchronous clear of both counters
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register write enable
- IFIDFlush  out  1  zero the IF/ID register at next edge
- IDEXBubble  out  1  load control zeros into ID/EX at next edge
- StallCnt  out  CNT_W  cycles with a stall asserted, saturating
- FlushCnt  out  CNT_W  cycles with IFIDFlush asserted, saturating

## Operation
- Matching. A register "matches" when it is nonzero and equal to IFIDRs, or when it is nonzero, IFIDUsesRt=1 and it equals IFIDRt.
- Hazard terms, evaluated combinationally from the inputs:
  - LU (load-use): IDEXMemRead and IDEXDst matches.
  - BA (branch on ALU result): IFIDBeq and IDEXRegWrite and !IDEXMemRead and IDEXDst matches.
  - BL (branch on load in EX): IFIDBeq and IDEXMemRead and IDEXDst matches.
  - BM (branch on load in MEM): IFIDBeq and EXMEMMemRead and EXMEMDst matches.
- FSM states are RUN and HOLD. The reset state is RUN.
- In RUN:
  - If BL: stall and go to HOLD.
  - Else if LU or BA or BM: stall and stay in RUN.
  - Else if IFIDBeq and BranchTaken: flush and stay in RUN.
  - Else: normal operation.
- In HOLD: stall unconditionally, ignore all hazard inputs and BranchTaken, and return to RUN.
- Stall output set: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0.
- Flush output set: PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=1.
- Normal output set: PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0.
- Priority: stall beats flush. BranchTaken is ignored in any stall cycle, because the comparator operands are not valid yet.
- Counters:
  - StallCnt increments on each edge where a stall was asserted.
  - FlushCnt increments on each edge where IFIDFlush was asserted.
  - Both saturate at 2^CNT_W−1 and do not wrap.
  - CntClr has priority over increment. On an edge with CntClr=1 the counter becomes 0 even if a stall or flush is asserted.

## Timing
- Outputs are combinational from the current state and inputs, so a stall or flush takes effect in the same cycle the hazard is presented. There is zero latency.
- Reset values while rst_n=0:
  - Outputs are forced to PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0.
  - State=RUN, StallCnt=0, FlushCnt=0.
  - No counting takes place.
- Reset asserted mid-HOLD: the state returns to RUN immediately, asynchronously. After release, the first edge evaluates the inputs fresh.
- Stall lengths:
  - Load-then-dependent-branch: exactly 2 stall cycles (one RUN cycle, then HOLD), then the branch resolves in the third cycle.
  - Load-use and ALU-then-branch: exactly 1 stall cycle, because the bubble then occupies EX and the hazard clears.
- LU and BL both true: BL wins, giving 2 stall cycles.
- A stall cycle increments StallCnt only and never FlushCnt.

## Test plan
- **Load-use:** IDEXMemRead=1, IDEXDst=8, IFIDRs=8, IFIDBeq=0 for one cycle, then IDEXMemRead=0 → stall for 1 cycle (PCWrite=0, IDEXBubble=1), then normal; StallCnt=1.
- **Load then branch:** IFIDBeq=1, IFIDRt=9, IFIDUsesRt=1, IDEXMemRead=1, IDEXDst=9, BranchTaken=1, with EX inputs cleared after the first edge → stall for 2 cycles with BranchTaken ignored, flush in the 3rd cycle; StallCnt=2, FlushCnt=1.
- **Register $0:** IDEXMemRead=1, IDEXDst=0, IFIDRs=0 → no stall. Separately, IFIDUsesRt=0 with IFIDRt matching IDEXDst=5 → no stall.
- **Taken branch, no hazard:** IFIDBeq=1, BranchTaken=1, no matches → IFIDFlush=1, PCWrite=1 in the same cycle; FlushCnt goes 0 to 1.
- **Counter saturation and clear:** with CNT_W=4, hold LU for 20 cycles → StallCnt stops at 15. Then CntClr=1 with LU still asserted → StallCnt=0 on that edge.
- **Reset in HOLD:** enter HOLD, then pulse rst_n low between edges → outputs are immediately the reset set and the counters read 0. After release with no hazard, normal operation resumes on the first cycle.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Stall/flush controller for a 5-stage pipeline with ID-stage branch resolution.
// Outputs are combinational from state and inputs; a two-state FSM extends load-then-branch stalls.
module hazard_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IDEXMemRead,
  input  logic             IDEXRegWrite,
  input  logic [4:0]       IDEXDst,
  input  logic             EXMEMMemRead,
  input  logic [4:0]       EXMEMDst,
  input  logic [4:0]       IFIDRs,
  input  logic [4:0]       IFIDRt,
  input  logic             IFIDUsesRt,
  input  logic             IFIDBeq,
  input  logic             BranchTaken,
  input  logic             CntClr,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_r;
  logic   lu_s, ba_s, bl_s, bm_s;
  logic   stall_s, flush_s, go_hold_s;

  // Register $0 never creates a dependency; rt only counts when the consumer reads it.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    reg_match = (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

  // Hazard terms from the current pipeline register contents
  always_comb begin
    lu_s = IDEXMemRead && reg_match(IDEXDst, IFIDRs, IFIDRt, IFIDUsesRt);
    ba_s = IFIDBeq && IDEXRegWrite && !IDEXMemRead && reg_match(IDEXDst, IFIDRs, IFIDRt, IFIDUsesRt);
    bl_s = IFIDBeq && IDEXMemRead && reg_match(IDEXDst, IFIDRs, IFIDRt, IFIDUsesRt);
    bm_s = IFIDBeq && EXMEMMemRead && reg_match(EXMEMDst, IFIDRs, IFIDRt, IFIDUsesRt);
  end

  // Stall/flush decision; a stall masks BranchTaken since the comparator operands are stale
  always_comb begin
    stall_s   = 1'b0;
    flush_s   = 1'b0;
    go_hold_s = 1'b0;
    case (state_r)
      RUN: begin
        if (bl_s) begin
          stall_s   = 1'b1;
          go_hold_s = 1'b1;
        end else if (lu_s || ba_s || bm_s) begin
          stall_s = 1'b1;
        end else if (IFIDBeq && BranchTaken) begin
          flush_s = 1'b1;
        end else begin
          stall_s = 1'b0;
        end
      end
      HOLD: begin
        stall_s = 1'b1;
      end
      default: begin
        stall_s = 1'b1;
      end
    endcase
  end

  // Pipeline control outputs, held in the stall set while reset is asserted
  always_comb begin
    if (!rst_n) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
      IFIDFlush  = 1'b0;
    end else if (stall_s) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
      IFIDFlush  = 1'b0;
    end else begin
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IDEXBubble = 1'b0;
      IFIDFlush  = flush_s;
    end
  end

  // FSM state: HOLD lasts exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else if (go_hold_s) begin
      state_r <= HOLD;
    end else begin
      state_r <= RUN;
    end
  end

  // Saturating stall counter, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt <= {CNT_W{1'b0}};
    end else if (CntClr) begin
      StallCnt <= {CNT_W{1'b0}};
    end else if (stall_s && (StallCnt != CNT_MAX)) begin
      StallCnt <= StallCnt + CNT_ONE;
    end else begin
      StallCnt <= StallCnt;
    end
  end

  // Saturating flush counter, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FlushCnt <= {CNT_W{1'b0}};
    end else if (CntClr) begin
      FlushCnt <= {CNT_W{1'b0}};
    end else if (flush_s && (FlushCnt != CNT_MAX)) begin
      FlushCnt <= FlushCnt + CNT_ONE;
    end else begin
      FlushCnt <= FlushCnt;
    end
  end

endmodule
